ex_stage: RTL

Execute stage of the pipelined RISC-V core. It sits directly downstream of the decode/execute pipeline register and consumes that register's valid/ready stream: operands, immediate, PC, register indices and control. It forwards results from the memory and writeback stages, computes the ALU result, and presents a registered result bundle to the memory stage through a 2-entry skid buffer.

---
 rtl/ex_pkg.sv | 20 ++
 rtl/ex_alu.sv | 23 ++
 rtl/ex_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage (ALU op encoding, result bundle, skid-buffer state).
package ex_pkg;
  localparam int DataWidth = 32;
  localparam int PcWidth = 64;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;
  typedef struct packed {
    logic [DataWidth-1:0] alu_result;
    logic [DataWidth-1:0] store_data;
    logic [PcWidth-1:0]   pc_imm;
    logic [3:0]           rd;
    logic                 reg_write;
    logic                 mem_write;
    logic                 mem_read;
    logic                 mem_to_reg;
    logic [2:0]           funct3;
  } ex_result_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/ex_alu.sv
// ex_alu: purely combinational 32-bit ALU; shifts use b[4:0], arithmetic wraps.
module ex_alu
  import ex_pkg::*;
(
  input  alu_op_e              op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  output logic [DataWidth-1:0] y
);
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SRA: y = $unsigned($signed(a) >>> b[4:0]);
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RISC-V execute stage with M/W operand forwarding (macro EX_FORWARDING_EN)
// and a 2-entry skid buffer toward the memory stage.
module ex_stage
  import ex_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DataWidth-1:0] readData1_i,
  input  logic [DataWidth-1:0] readData2_i,
  input  logic [PcWidth-1:0]   immediate_i,
  input  logic [PcWidth-1:0]   PC_i,
  input  logic [3:0]           rd_i,
  input  logic [3:0]           rs1_i,
  input  logic [3:0]           rs2_i,
  input  logic                 RegWrite_i,
  input  logic                 MemWrite_i,
  input  logic                 MemRead_i,
  input  logic                 ALUSrc_i,
  input  logic                 MemToReg_i,
  input  logic [2:0]           ALUOp_i,
  input  logic [2:0]           funct3_i,
  input  logic [2:0]           I_Type_i,
  input  logic                 fwd_m_valid_i,
  input  logic [3:0]           fwd_m_rd_i,
  input  logic [DataWidth-1:0] fwd_m_data_i,
  input  logic                 fwd_w_valid_i,
  input  logic [3:0]           fwd_w_rd_i,
  input  logic [DataWidth-1:0] fwd_w_data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] alu_result_o,
  output logic [DataWidth-1:0] store_data_o,
  output logic [PcWidth-1:0]   pc_imm_o,
  output logic [3:0]           rd_o,
  output logic                 RegWrite_o,
  output logic                 MemWrite_o,
  output logic                 MemRead_o,
  output logic                 MemToReg_o,
  output logic [2:0]           funct3_o
);
  logic [DataWidth-1:0] rs1_val, rs2_val, op_b, alu_y;
  ex_result_t in_res, head, skid;
  skid_state_e state, state_d;
  logic push, pop;
`ifdef EX_FORWARDING_EN
  // M has priority over W since it holds the younger value; x0 never forwards.
  assign rs1_val = (fwd_m_valid_i && fwd_m_rd_i == rs1_i && rs1_i != '0) ? fwd_m_data_i :
                   (fwd_w_valid_i && fwd_w_rd_i == rs1_i && rs1_i != '0) ? fwd_w_data_i : readData1_i;
  assign rs2_val = (fwd_m_valid_i && fwd_m_rd_i == rs2_i && rs2_i != '0) ? fwd_m_data_i :
                   (fwd_w_valid_i && fwd_w_rd_i == rs2_i && rs2_i != '0) ? fwd_w_data_i : readData2_i;
  logic unused_ok;
  assign unused_ok = ^{I_Type_i};
`else
  assign rs1_val = readData1_i;
  assign rs2_val = readData2_i;
  logic unused_ok;
  assign unused_ok = ^{I_Type_i, rs1_i, rs2_i, fwd_m_valid_i, fwd_m_rd_i, fwd_m_data_i,
                       fwd_w_valid_i, fwd_w_rd_i, fwd_w_data_i};
`endif
  assign op_b = ALUSrc_i ? immediate_i[DataWidth-1:0] : rs2_val;
  ex_alu u_alu (.op(alu_op_e'(ALUOp_i)), .a(rs1_val), .b(op_b), .y(alu_y));
  assign in_res = '{alu_result: alu_y, store_data: rs2_val, pc_imm: PC_i + immediate_i,
                    rd: rd_i, reg_write: RegWrite_i, mem_write: MemWrite_i,
                    mem_read: MemRead_i, mem_to_reg: MemToReg_i, funct3: funct3_i};
  assign valid_o = state != EMPTY;
  assign ready_o = state != TWO;
  assign push = valid_i && ready_o && !flush_i;
  assign pop = valid_o && ready_i;
  always_comb begin
    state_d = state;
    if (flush_i) state_d = EMPTY;
    else if (state == EMPTY) state_d = push ? ONE : EMPTY;
    else if (state == ONE) state_d = (push && !pop) ? TWO : (!push && pop) ? EMPTY : ONE;
    else state_d = pop ? ONE : TWO;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= EMPTY;
      head <= '0;
      skid <= '0;
    end else begin
      state <= state_d;
      if (push && (state == EMPTY || pop)) head <= in_res;
      else if (state == TWO && pop) head <= skid;
      if (push && state == ONE && !pop) skid <= in_res;
    end
  end
  assign alu_result_o = head.alu_result;
  assign store_data_o = head.store_data;
  assign pc_imm_o = head.pc_imm;
  assign rd_o = head.rd;
  assign RegWrite_o = head.reg_write;
  assign MemWrite_o = head.mem_write;
  assign MemRead_o = head.mem_read;
  assign MemToReg_o = head.mem_to_reg;
  assign funct3_o = head.funct3;
endmodule
